// File: rtl/robo_controlador.sv
// Left-hand-rule wall follower that sequences the map/sensor block.
// Each 3-cycle decision reads head/left and issues a forward move or a quarter turn.
module robo_controlador #(
   parameter int         MAX_PASSOS     = 200,
   parameter int         PASSOS_W       = 8,
   parameter logic [2:0] ORIENT_INICIAL = 3'b001
) (
   input  logic                clockc1,
   input  logic                reset,
   input  logic                iniciar,
   input  logic                parar,
   input  logic                head,
   input  logic                left,
   output logic [2:0]          acao,
   output logic [2:0]          orientacao,
   output logic                ocupado,
   output logic                concluido,
   output logic                erro,
   output logic [PASSOS_W-1:0] passos
);

   typedef enum logic [2:0] {
      OCIOSO,
      ESPERA1,
      ESPERA2,
      DECIDE,
      CONCLUIDO,
      ERRO
   } estado_t;

   localparam logic [2:0] NORTE = 3'b001;
   localparam logic [2:0] OESTE = 3'b010;
   localparam logic [2:0] LESTE = 3'b011;
   localparam logic [2:0] SUL   = 3'b100;

   estado_t             estado, estado_n;
   logic [2:0]          acao_n, orientacao_n;
   logic [PASSOS_W-1:0] passos_n;
   logic [1:0]          giros, giros_n;
   logic                virou_esq, virou_esq_n;
   logic                ocupado_n, concluido_n, erro_n;

   function automatic logic [2:0] gira_esq(input logic [2:0] o);
      case (o)
         NORTE:   gira_esq = OESTE;
         OESTE:   gira_esq = SUL;
         SUL:     gira_esq = LESTE;
         LESTE:   gira_esq = NORTE;
         default: gira_esq = NORTE;
      endcase
   endfunction

   function automatic logic [2:0] gira_dir(input logic [2:0] o);
      case (o)
         NORTE:   gira_dir = LESTE;
         LESTE:   gira_dir = SUL;
         SUL:     gira_dir = OESTE;
         OESTE:   gira_dir = NORTE;
         default: gira_dir = NORTE;
      endcase
   endfunction

   always_ff @(posedge clockc1 or posedge reset) begin
      if (reset) begin
         estado     <= OCIOSO;
         acao       <= 3'b000;
         orientacao <= ORIENT_INICIAL;
         passos     <= '0;
         giros      <= 2'd0;
         virou_esq  <= 1'b0;
         ocupado    <= 1'b0;
         concluido  <= 1'b0;
         erro       <= 1'b0;
      end else begin
         estado     <= estado_n;
         acao       <= acao_n;
         orientacao <= orientacao_n;
         passos     <= passos_n;
         giros      <= giros_n;
         virou_esq  <= virou_esq_n;
         ocupado    <= ocupado_n;
         concluido  <= concluido_n;
         erro       <= erro_n;
      end
   end

   // acao defaults to 000 so a move command lives only in the cycle after DECIDE
   always_comb begin
      estado_n     = estado;
      acao_n       = 3'b000;
      orientacao_n = orientacao;
      passos_n     = passos;
      giros_n      = giros;
      virou_esq_n  = virou_esq;

      case (estado)
         OCIOSO, CONCLUIDO, ERRO: begin
            if (iniciar) begin
               estado_n    = ESPERA1;
               passos_n    = '0;
               giros_n     = 2'd0;
               virou_esq_n = 1'b0;
            end
         end
         ESPERA1: estado_n = ESPERA2;
         ESPERA2: estado_n = DECIDE;
         DECIDE: begin
            if (parar) begin
               estado_n = CONCLUIDO;
            end else if (passos == PASSOS_W'(MAX_PASSOS)) begin
               estado_n = CONCLUIDO;
            end else if (!left && !virou_esq) begin
               orientacao_n = gira_esq(orientacao);
               virou_esq_n  = 1'b1;
               giros_n      = 2'd0;
               estado_n     = ESPERA1;
            end else if (!head) begin
               acao_n      = orientacao;
               passos_n    = passos + PASSOS_W'(1);
               virou_esq_n = 1'b0;
               giros_n     = 2'd0;
               estado_n    = ESPERA1;
            end else if (giros == 2'd3) begin
               estado_n = ERRO;
            end else begin
               orientacao_n = gira_dir(orientacao);
               virou_esq_n  = 1'b0;
               giros_n      = giros + 2'd1;
               estado_n     = ESPERA1;
            end
         end
         default: estado_n = OCIOSO;
      endcase

      ocupado_n   = (estado_n == ESPERA1) || (estado_n == ESPERA2) || (estado_n == DECIDE);
      concluido_n = (estado_n == CONCLUIDO);
      erro_n      = (estado_n == ERRO);
   end

endmodule

// File: tb/tb_robo_controlador.sv
// Bench for robo_controlador: directed table, corner sequences and random run vs a heading-index model.
module tb_robo_controlador;

   localparam int MAXP = 5;

   logic       clockc1, reset, iniciar, parar, head, left;
   logic [2:0] acao, orientacao;
   logic       ocupado, concluido, erro;
   logic [7:0] passos;

   int checks = 0;
   int errors = 0;

   robo_controlador #(.MAX_PASSOS(MAXP), .PASSOS_W(8), .ORIENT_INICIAL(3'b001)) dut (
      .clockc1(clockc1), .reset(reset), .iniciar(iniciar), .parar(parar),
      .head(head), .left(left), .acao(acao), .orientacao(orientacao),
      .ocupado(ocupado), .concluido(concluido), .erro(erro), .passos(passos)
   );

   initial clockc1 = 1'b0;
   always #5 clockc1 = ~clockc1;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Heading kept as a counter-clockwise index: N, W, S, E. Left is +1, right is +3.
   logic [2:0] codes [4] = '{3'b001, 3'b010, 3'b100, 3'b011};
   int   m_mode;   // 0 idle, 1 running, 2 done, 3 error
   int   m_phase;  // 0 command cycle, 1 settle, 2 decide
   int   m_h, m_steps, m_rights;
   bit   m_just_left;
   logic [2:0] m_acao;

   typedef struct {
      logic ini, par, hd, lf;
      logic [2:0] acao, ori;
      logic ocup, conc, err;
      logic [7:0] pas;
   } vec_t;
   vec_t tbl [21];

   task automatic modelReset();
      m_mode = 0; m_phase = 0; m_h = 0; m_steps = 0; m_rights = 0;
      m_just_left = 0; m_acao = 3'b000;
   endtask

   task automatic modelStep(input logic ini, input logic par, input logic hd, input logic lf);
      m_acao = 3'b000;
      if (m_mode != 1) begin
         if (ini) begin
            m_mode = 1; m_phase = 0; m_steps = 0; m_rights = 0; m_just_left = 0;
         end
      end else if (m_phase < 2) begin
         m_phase++;
      end else begin
         m_phase = 0;
         if (par || m_steps == MAXP) m_mode = 2;
         else if (!lf && !m_just_left) begin
            m_h = (m_h + 1) % 4; m_just_left = 1; m_rights = 0;
         end else if (!hd) begin
            m_acao = codes[m_h]; m_steps++; m_just_left = 0; m_rights = 0;
         end else if (m_rights == 3) m_mode = 3;
         else begin
            m_h = (m_h + 3) % 4; m_just_left = 0; m_rights++;
         end
      end
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic ini, input logic par, input logic hd, input logic lf);
      iniciar = ini; parar = par; head = hd; left = lf;
      modelStep(ini, par, hd, lf);
      @(posedge clockc1);
      #1;
   endtask

   task automatic checkOutput(input string tag);
      check({tag, ".acao"},       32'(acao),       32'(m_acao));
      check({tag, ".orientacao"}, 32'(orientacao), 32'(codes[m_h]));
      check({tag, ".passos"},     32'(passos),     32'(m_steps));
      check({tag, ".ocupado"},    32'(ocupado),    32'(m_mode == 1));
      check({tag, ".concluido"},  32'(concluido),  32'(m_mode == 2));
      check({tag, ".erro"},       32'(erro),       32'(m_mode == 3));
   endtask

   task automatic doReset();
      reset = 1'b1; iniciar = 1'b0; parar = 1'b0; head = 1'b0; left = 1'b0;
      repeat (2) @(posedge clockc1);
      #1;
      reset = 1'b0;
      modelReset();
      checkOutput("reset");
   endtask

   initial begin
      logic ri, rp, rh, rl;

      tbl[0]  = '{1'b1,1'b0,1'b0,1'b1, 3'b000,3'b001, 1'b1,1'b0,1'b0, 8'd0};
      tbl[1]  = '{1'b0,1'b0,1'b0,1'b1, 3'b000,3'b001, 1'b1,1'b0,1'b0, 8'd0};
      tbl[2]  = '{1'b0,1'b0,1'b0,1'b1, 3'b000,3'b001, 1'b1,1'b0,1'b0, 8'd0};
      tbl[3]  = '{1'b0,1'b0,1'b0,1'b1, 3'b001,3'b001, 1'b1,1'b0,1'b0, 8'd1};
      tbl[4]  = '{1'b0,1'b0,1'b0,1'b1, 3'b000,3'b001, 1'b1,1'b0,1'b0, 8'd1};
      tbl[5]  = '{1'b0,1'b0,1'b0,1'b1, 3'b000,3'b001, 1'b1,1'b0,1'b0, 8'd1};
      tbl[6]  = '{1'b0,1'b0,1'b0,1'b1, 3'b001,3'b001, 1'b1,1'b0,1'b0, 8'd2};
      tbl[7]  = '{1'b0,1'b0,1'b0,1'b1, 3'b000,3'b001, 1'b1,1'b0,1'b0, 8'd2};
      tbl[8]  = '{1'b0,1'b0,1'b0,1'b1, 3'b000,3'b001, 1'b1,1'b0,1'b0, 8'd2};
      tbl[9]  = '{1'b0,1'b0,1'b0,1'b1, 3'b001,3'b001, 1'b1,1'b0,1'b0, 8'd3};
      tbl[10] = '{1'b0,1'b0,1'b1,1'b0, 3'b000,3'b001, 1'b1,1'b0,1'b0, 8'd3};
      tbl[11] = '{1'b0,1'b0,1'b1,1'b0, 3'b000,3'b001, 1'b1,1'b0,1'b0, 8'd3};
      tbl[12] = '{1'b0,1'b0,1'b1,1'b0, 3'b000,3'b010, 1'b1,1'b0,1'b0, 8'd3};
      tbl[13] = '{1'b0,1'b0,1'b0,1'b0, 3'b000,3'b010, 1'b1,1'b0,1'b0, 8'd3};
      tbl[14] = '{1'b0,1'b0,1'b0,1'b0, 3'b000,3'b010, 1'b1,1'b0,1'b0, 8'd3};
      tbl[15] = '{1'b0,1'b0,1'b0,1'b0, 3'b010,3'b010, 1'b1,1'b0,1'b0, 8'd4};
      tbl[16] = '{1'b0,1'b1,1'b0,1'b0, 3'b000,3'b010, 1'b1,1'b0,1'b0, 8'd4};
      tbl[17] = '{1'b0,1'b0,1'b0,1'b0, 3'b000,3'b010, 1'b1,1'b0,1'b0, 8'd4};
      tbl[18] = '{1'b0,1'b1,1'b0,1'b0, 3'b000,3'b010, 1'b0,1'b1,1'b0, 8'd4};
      tbl[19] = '{1'b0,1'b0,1'b0,1'b0, 3'b000,3'b010, 1'b0,1'b1,1'b0, 8'd4};
      tbl[20] = '{1'b1,1'b0,1'b0,1'b0, 3'b000,3'b010, 1'b1,1'b0,1'b0, 8'd0};

      doReset();
      for (int i = 0; i < 21; i++) begin
         applyStimulus(tbl[i].ini, tbl[i].par, tbl[i].hd, tbl[i].lf);
         check($sformatf("tbl%0d.acao", i),       32'(acao),       32'(tbl[i].acao));
         check($sformatf("tbl%0d.orientacao", i), 32'(orientacao), 32'(tbl[i].ori));
         check($sformatf("tbl%0d.ocupado", i),    32'(ocupado),    32'(tbl[i].ocup));
         check($sformatf("tbl%0d.concluido", i),  32'(concluido),  32'(tbl[i].conc));
         check($sformatf("tbl%0d.erro", i),       32'(erro),       32'(tbl[i].err));
         check($sformatf("tbl%0d.passos", i),     32'(passos),     32'(tbl[i].pas));
      end

      // Boxed in: three right turns, then the fourth blocked decision errors out
      doReset();
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
      checkOutput("box_start");
      for (int d = 0; d < 4; d++) begin
         applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
         checkOutput("box");
         applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
         checkOutput("box_busy_iniciar");
         applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
         checkOutput("box");
         if (d == 0) check("box_turn1", 32'(orientacao), 32'(3'b011));
         if (d == 1) check("box_turn2", 32'(orientacao), 32'(3'b100));
         if (d == 2) check("box_turn3", 32'(orientacao), 32'(3'b010));
      end
      check("box_erro", 32'(erro), 32'd1);
      check("box_ocupado", 32'(ocupado), 32'd0);
      check("box_acao", 32'(acao), 32'd0);

      // Free corridor until the step limit, then restart
      doReset();
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
      for (int n = 0; n < 3 * MAXP + 3; n++) begin
         applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
         checkOutput("limit");
      end
      check("limit_concluido", 32'(concluido), 32'd1);
      check("limit_passos", 32'(passos), 32'(MAXP));
      for (int n = 0; n < 3; n++) begin
         applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
         check("limit_acao_idle", 32'(acao), 32'd0);
      end
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
      checkOutput("limit_restart");
      check("limit_restart_passos", 32'(passos), 32'd0);

      // parar coinciding with the step limit still ends cleanly
      for (int n = 0; n < 3 * MAXP + 2; n++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
      checkOutput("stop_limit");
      check("stop_limit_erro", 32'(erro), 32'd0);
      check("stop_limit_conc", 32'(concluido), 32'd1);

      // Asynchronous reset while an east move is on acao
      doReset();
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
      for (int n = 0; n < 3; n++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
      for (int n = 0; n < 3; n++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      check("mid_acao_east", 32'(acao), 32'(3'b011));
      #2 reset = 1'b1;
      #1;
      check("mid_reset_acao", 32'(acao), 32'd0);
      check("mid_reset_orient", 32'(orientacao), 32'(3'b001));
      check("mid_reset_passos", 32'(passos), 32'd0);
      check("mid_reset_ocupado", 32'(ocupado), 32'd0);
      #2 reset = 1'b0;
      modelReset();

      // Random sensors and control against the model
      for (int run = 0; run < 4; run++) begin
         doReset();
         for (int n = 0; n < 150; n++) begin
            ri = ($urandom_range(0, 9) == 0);
            rp = ($urandom_range(0, 15) == 0);
            rh = ($urandom_range(0, 9) < 4);
            rl = ($urandom_range(0, 1) == 1);
            applyStimulus(ri, rp, rh, rl);
            checkOutput($sformatf("rand%0d_%0d", run, n));
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
